// File: rtl/sdram_arbit.sv
// sdram_arbit: SDRAM command arbiter and pin multiplexer.
// Sequences initialisation, then grants one requester at a time with fixed
// priority refresh > write > read, routing the granted module's command,
// bank and address to the SDRAM pins until that module signals its end.
// Optional feature macro: SDRAM_ARBIT_WDOG_EN (grant-duration watchdog).
module sdram_arbit #(
  parameter int WDOG_MAX = 1023
) (
  input  logic        sclk,
  input  logic        s_rst_n,
  // initialisation
  input  logic [3:0]  init_cmd,
  input  logic [12:0] init_addr,
  input  logic        flag_init_end,
  // auto-refresh
  input  logic        ref_req,
  output logic        ref_en,
  input  logic        flag_ref_end,
  input  logic [3:0]  aref_cmd,
  input  logic [12:0] ref_addr,
  // write
  input  logic        wr_req,
  output logic        wr_en,
  input  logic        flag_wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [1:0]  wr_bank,
  input  logic [12:0] wr_addr,
  // read
  input  logic        rd_req,
  output logic        rd_en,
  input  logic        flag_rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [1:0]  rd_bank,
  input  logic [12:0] rd_addr,
  // SDRAM pins
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_bank,
  output logic [12:0] sdram_addr,
  output logic        wdog_err
);

  localparam logic [2:0] INIT  = 3'd0;
  localparam logic [2:0] ARBIT = 3'd1;
  localparam logic [2:0] AREF  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] READ  = 3'd4;

  localparam logic [3:0] CMD_NOP = 4'b0111;

  logic [2:0]  state_r;
  logic [2:0]  next_s;
  logic        ref_en_r;
  logic        wr_en_r;
  logic        rd_en_r;
  logic        wdog_err_r;
  logic        timeout_s;
  logic        grant_end_s;
  logic [3:0]  cmd_s;
  logic [1:0]  bank_s;
  logic [12:0] addr_s;

`ifdef SDRAM_ARBIT_WDOG_EN
  localparam int WDOG_W = ($clog2(WDOG_MAX + 1) > 11) ? $clog2(WDOG_MAX + 1) : 11;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_MAX - 1);

  logic [WDOG_W-1:0] wdog_cnt_r;

  // Watchdog expiry: the current grant has lasted WDOG_MAX cycles and its end flag is still low.
  always_comb begin
    timeout_s = 1'b0;
    if ((state_r == AREF || state_r == WRITE || state_r == READ) &&
        (wdog_cnt_r == WDOG_LAST) && !grant_end_s) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Grant-duration counter: counts while a grant state persists, zero on entry and elsewhere.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      wdog_cnt_r <= {WDOG_W{1'b0}};
    end else if ((state_r == AREF || state_r == WRITE || state_r == READ) &&
                 (next_s == state_r)) begin
      wdog_cnt_r <= wdog_cnt_r + {{(WDOG_W-1){1'b0}}, 1'b1};
    end else begin
      wdog_cnt_r <= {WDOG_W{1'b0}};
    end
  end
`else
  logic unused_wdog_s;

  assign timeout_s     = 1'b0;
  assign unused_wdog_s = (WDOG_MAX != 32'sd0);
`endif

  // End flag of the module that currently holds the grant; others are ignored.
  always_comb begin
    grant_end_s = 1'b0;
    case (state_r)
      AREF:    grant_end_s = flag_ref_end;
      WRITE:   grant_end_s = flag_wr_end;
      READ:    grant_end_s = flag_rd_end;
      default: grant_end_s = 1'b0;
    endcase
  end

  // Next-state logic: init handshake, fixed-priority arbitration, return on end flag or watchdog.
  always_comb begin
    next_s = state_r;
    case (state_r)
      INIT: begin
        if (flag_init_end) begin
          next_s = ARBIT;
        end else begin
          next_s = INIT;
        end
      end
      ARBIT: begin
        if (ref_req) begin
          next_s = AREF;
        end else if (wr_req) begin
          next_s = WRITE;
        end else if (rd_req) begin
          next_s = READ;
        end else begin
          next_s = ARBIT;
        end
      end
      AREF, WRITE, READ: begin
        if (grant_end_s || timeout_s) begin
          next_s = ARBIT;
        end else begin
          next_s = state_r;
        end
      end
      default: next_s = INIT;
    endcase
  end

  // State register.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_r <= INIT;
    end else begin
      state_r <= next_s;
    end
  end

  // Grant pulses: high only in the first cycle of the granted state; watchdog abort pulse.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      ref_en_r   <= 1'b0;
      wr_en_r    <= 1'b0;
      rd_en_r    <= 1'b0;
      wdog_err_r <= 1'b0;
    end else begin
      ref_en_r   <= (state_r == ARBIT) && (next_s == AREF);
      wr_en_r    <= (state_r == ARBIT) && (next_s == WRITE);
      rd_en_r    <= (state_r == ARBIT) && (next_s == READ);
      wdog_err_r <= timeout_s;
    end
  end

  // Pin multiplexer: selects command, bank and address from the current owner.
  always_comb begin
    cmd_s  = CMD_NOP;
    bank_s = 2'b00;
    addr_s = 13'd0;
    case (state_r)
      INIT: begin
        cmd_s  = init_cmd;
        bank_s = 2'b00;
        addr_s = init_addr;
      end
      ARBIT: begin
        cmd_s  = CMD_NOP;
        bank_s = 2'b00;
        addr_s = 13'd0;
      end
      AREF: begin
        cmd_s  = aref_cmd;
        bank_s = 2'b00;
        addr_s = ref_addr;
      end
      WRITE: begin
        cmd_s  = wr_cmd;
        bank_s = wr_bank;
        addr_s = wr_addr;
      end
      READ: begin
        cmd_s  = rd_cmd;
        bank_s = rd_bank;
        addr_s = rd_addr;
      end
      default: begin
        cmd_s  = CMD_NOP;
        bank_s = 2'b00;
        addr_s = 13'd0;
      end
    endcase
  end

  assign sdram_cke   = 1'b1;
  assign sdram_cs_n  = cmd_s[3];
  assign sdram_ras_n = cmd_s[2];
  assign sdram_cas_n = cmd_s[1];
  assign sdram_we_n  = cmd_s[0];
  assign sdram_bank  = bank_s;
  assign sdram_addr  = addr_s;
  assign ref_en      = ref_en_r;
  assign wr_en       = wr_en_r;
  assign rd_en       = rd_en_r;
  assign wdog_err    = wdog_err_r;

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed table-driven bench for sdram_arbit, plus hand sequences for
// reset-during-grant and grant-duration (watchdog) behaviour.
module tb_sdram_arbit;

  localparam logic [3:0]  C_INIT  = 4'b0010;
  localparam logic [3:0]  C_NOP   = 4'b0111;
  localparam logic [3:0]  C_AREF  = 4'b0001;
  localparam logic [3:0]  C_WR    = 4'b0100;
  localparam logic [3:0]  C_RD    = 4'b0101;
  localparam logic [12:0] A_INIT  = 13'h0AAA;
  localparam logic [12:0] A_REF   = 13'h0400;
  localparam logic [12:0] A_WR    = 13'h0123;
  localparam logic [12:0] A_RD    = 13'h0456;
  localparam logic [1:0]  B_WR    = 2'b10;
  localparam logic [1:0]  B_RD    = 2'b01;

  logic        sclk;
  logic        s_rst_n;
  logic        flag_init_end;
  logic        ref_req, wr_req, rd_req;
  logic        flag_ref_end, flag_wr_end, flag_rd_end;
  logic        ref_en, wr_en, rd_en;
  logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_bank;
  logic [12:0] sdram_addr;
  logic        wdog_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  sdram_arbit #(.WDOG_MAX(15)) dut (
    .sclk(sclk), .s_rst_n(s_rst_n),
    .init_cmd(C_INIT), .init_addr(A_INIT), .flag_init_end(flag_init_end),
    .ref_req(ref_req), .ref_en(ref_en), .flag_ref_end(flag_ref_end),
    .aref_cmd(C_AREF), .ref_addr(A_REF),
    .wr_req(wr_req), .wr_en(wr_en), .flag_wr_end(flag_wr_end),
    .wr_cmd(C_WR), .wr_bank(B_WR), .wr_addr(A_WR),
    .rd_req(rd_req), .rd_en(rd_en), .flag_rd_end(flag_rd_end),
    .rd_cmd(C_RD), .rd_bank(B_RD), .rd_addr(A_RD),
    .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_bank(sdram_bank), .sdram_addr(sdram_addr), .wdog_err(wdog_err)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  typedef struct {
    logic        init_end;
    logic [2:0]  req;    // {ref, wr, rd}
    logic [2:0]  endf;   // {ref, wr, rd}
    logic [3:0]  cmd;
    logic [1:0]  bank;
    logic [12:0] addr;
    logic [2:0]  en;     // {ref, wr, rd}
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(logic ie, logic [2:0] rq, logic [2:0] ef,
                              logic [3:0] c, logic [1:0] b, logic [12:0] a,
                              logic [2:0] e);
    vec_t v;
    v.init_end = ie; v.req = rq; v.endf = ef;
    v.cmd = c; v.bank = b; v.addr = a; v.en = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic check_pins(input string tag, input logic [3:0] c, input logic [1:0] b,
                            input logic [12:0] a, input logic [2:0] e);
    check({tag, ".cmd"},  {28'd0, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, {28'd0, c});
    check({tag, ".bank"}, {30'd0, sdram_bank}, {30'd0, b});
    check({tag, ".addr"}, {19'd0, sdram_addr}, {19'd0, a});
    check({tag, ".en"},   {29'd0, ref_en, wr_en, rd_en}, {29'd0, e});
  endtask

  task automatic drive(input logic ie, input logic [2:0] rq, input logic [2:0] ef);
    flag_init_end = ie;
    {ref_req, wr_req, rd_req} = rq;
    {flag_ref_end, flag_wr_end, flag_rd_end} = ef;
  endtask

  initial begin
    // Each row: inputs sampled at an edge, expected outputs just after that edge.
    vecs[0]  = mk(1'b0, 3'b000, 3'b000, C_INIT, 2'b00, A_INIT, 3'b000); // hold in INIT
    vecs[1]  = mk(1'b1, 3'b000, 3'b000, C_NOP,  2'b00, 13'd0,  3'b000); // init done
    vecs[2]  = mk(1'b0, 3'b000, 3'b000, C_NOP,  2'b00, 13'd0,  3'b000); // init_end drop ignored
    vecs[3]  = mk(1'b0, 3'b100, 3'b000, C_AREF, 2'b00, A_REF,  3'b100); // refresh grant
    vecs[4]  = mk(1'b0, 3'b100, 3'b000, C_AREF, 2'b00, A_REF,  3'b000); // pulse one cycle only
    vecs[5]  = mk(1'b0, 3'b000, 3'b100, C_NOP,  2'b00, 13'd0,  3'b000); // refresh end
    vecs[6]  = mk(1'b0, 3'b111, 3'b000, C_AREF, 2'b00, A_REF,  3'b100); // all req: refresh wins
    vecs[7]  = mk(1'b0, 3'b111, 3'b100, C_NOP,  2'b00, 13'd0,  3'b000); // end -> NOP gap
    vecs[8]  = mk(1'b0, 3'b011, 3'b000, C_WR,   B_WR,  A_WR,   3'b010); // write next
    vecs[9]  = mk(1'b0, 3'b001, 3'b001, C_WR,   B_WR,  A_WR,   3'b000); // stray rd end ignored
    vecs[10] = mk(1'b0, 3'b001, 3'b100, C_WR,   B_WR,  A_WR,   3'b000); // stray ref end ignored
    vecs[11] = mk(1'b0, 3'b001, 3'b010, C_NOP,  2'b00, 13'd0,  3'b000); // write end
    vecs[12] = mk(1'b0, 3'b001, 3'b000, C_RD,   B_RD,  A_RD,   3'b001); // read grant
    vecs[13] = mk(1'b0, 3'b000, 3'b001, C_NOP,  2'b00, 13'd0,  3'b000); // read end
    vecs[14] = mk(1'b0, 3'b010, 3'b000, C_WR,   B_WR,  A_WR,   3'b010); // write grant
    vecs[15] = mk(1'b0, 3'b000, 3'b010, C_NOP,  2'b00, 13'd0,  3'b000); // end on pulse cycle
    vecs[16] = mk(1'b0, 3'b001, 3'b000, C_RD,   B_RD,  A_RD,   3'b001); // read grant

    s_rst_n = 1'b0;
    drive(1'b0, 3'b000, 3'b000);
    #12;
    check_pins("reset", C_INIT, 2'b00, A_INIT, 3'b000);
    check("reset.cke", {31'd0, sdram_cke}, 32'd1);
    check("reset.wdog", {31'd0, wdog_err}, 32'd0);
    s_rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].init_end, vecs[i].req, vecs[i].endf);
      @(posedge sclk);
      #1;
      check_pins($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].bank, vecs[i].addr, vecs[i].en);
    end

    // Reset asserted while the read grant pulse is high.
    drive(1'b0, 3'b000, 3'b000);
    s_rst_n = 1'b0;
    #1;
    check_pins("rst_mid_read", C_INIT, 2'b00, A_INIT, 3'b000);
    @(posedge sclk);
    #1;
    check_pins("rst_hold", C_INIT, 2'b00, A_INIT, 3'b000);
    check("rst_hold.cke", {31'd0, sdram_cke}, 32'd1);
    s_rst_n = 1'b1;

    // Long write with no end flag.
    drive(1'b1, 3'b000, 3'b000);
    @(posedge sclk);
    #1;
    check_pins("wd.arbit", C_NOP, 2'b00, 13'd0, 3'b000);
    drive(1'b0, 3'b010, 3'b000);
    @(posedge sclk);
    #1;
    check_pins("wd.grant", C_WR, B_WR, A_WR, 3'b010);
    drive(1'b0, 3'b000, 3'b000);
`ifdef SDRAM_ARBIT_WDOG_EN
    for (int k = 0; k < 14; k++) begin
      @(posedge sclk);
      #1;
      check($sformatf("wd.hold%0d.cmd", k), {28'd0, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, {28'd0, C_WR});
      check($sformatf("wd.hold%0d.err", k), {31'd0, wdog_err}, 32'd0);
    end
    @(posedge sclk);
    #1;
    check_pins("wd.abort", C_NOP, 2'b00, 13'd0, 3'b000);
    check("wd.abort.err", {31'd0, wdog_err}, 32'd1);
    @(posedge sclk);
    #1;
    check("wd.after.err", {31'd0, wdog_err}, 32'd0);
    check_pins("wd.after", C_NOP, 2'b00, 13'd0, 3'b000);
`else
    for (int k = 0; k < 40; k++) begin
      @(posedge sclk);
      #1;
      check($sformatf("wd.hold%0d.cmd", k), {28'd0, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, {28'd0, C_WR});
      check($sformatf("wd.hold%0d.err", k), {31'd0, wdog_err}, 32'd0);
    end
    drive(1'b0, 3'b000, 3'b010);
    @(posedge sclk);
    #1;
    check_pins("wd.end", C_NOP, 2'b00, 13'd0, 3'b000);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
